// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end and the pipeline flush path.
package fetch_prefetch_queue_pkg;
    localparam int               FPQ_XLEN      = 32;
    localparam logic [31:0]      FPQ_RESET_PC  = 32'h0000_0000;
    // add x0,x0,x0: a bubble that IF/ID and the flush path can inject safely.
    localparam logic [31:0]      FPQ_NOP_INSTR = 32'h0000_0033;

    typedef struct packed {
        logic [FPQ_XLEN-1:0] pc;
        logic [FPQ_XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory port plus the valid/ready delivery port toward IF/ID.
interface fetch_prefetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    // The fetch unit drives the memory request and the IF/ID payload.
    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_rdata, out_ready
    );

    // Memory model and IF/ID register side.
    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; no write-to-read bypass.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    // Storage array: written on push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, fetches into a prefetch FIFO only when
// the shared memory is free, and hands {pc, instr} to IF/ID.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              XLEN      = FPQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FPQ_RESET_PC),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(FPQ_NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_busy,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    fetch_prefetch_queue_if.master   bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]   fetch_pc;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [2*XLEN-1:0] head;

    // Redirect hides the head and blocks the fetch so nothing stale crosses
    // the flush edge in either direction.
    assign bus.out_valid = !empty && !redirect_valid;
    assign pop           = bus.out_valid && bus.out_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign push          = rst && !mem_busy && !redirect_valid && (!full || pop);

    assign bus.imem_req  = push;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_pc    = bus.out_valid ? head[2*XLEN-1:XLEN] : '0;
    assign bus.out_instr = bus.out_valid ? head[XLEN-1:0]      : NOP_INSTR;

    // Fetch PC: reload on redirect, step by one word on each issued fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= redirect_pc;
        else if (push)
            fetch_pc <= fetch_pc + PC_STEP;
    end

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, bus.imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for the fetch prefetch queue; memory returns 0x100 + addr.
module tb_fetch_prefetch_queue;
    logic        clk;
    logic        rst;
    logic        mem_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    int          total;
    int          bad;

    fetch_prefetch_queue_if #(.XLEN(32)) bus ();

    fetch_prefetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_busy       (mem_busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .count          (count)
    );

    assign bus.imem_rdata = bus.imem_addr + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_busy = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bus.out_ready = 1'b0;
        #12;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.out_pc); end
        total++; if (bus.out_instr !== 32'h33) begin bad++; $display("FAIL rst_instr got=%h exp=33", bus.out_instr); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill();
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL fill_req[%0d] got=%b exp=1", i, bus.imem_req); end
            total++; if (bus.imem_addr !== 32'(4*i)) begin bad++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, bus.imem_addr, 32'(4*i)); end
            tick();
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL fill_full_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL fill_hold_addr got=%h exp=10", bus.imem_addr); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL fill_pc got=%h exp=0", bus.out_pc); end
        total++; if (bus.out_instr !== 32'h100) begin bad++; $display("FAIL fill_instr got=%h exp=100", bus.out_instr); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.out_pc !== 32'(4*k)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, bus.out_pc, 32'(4*k)); end
            total++; if (bus.out_instr !== 32'(32'h100 + 4*k)) begin bad++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, bus.out_instr, 32'(32'h100 + 4*k)); end
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL b2b_req[%0d] got=%b exp=1", k, bus.imem_req); end
            total++; if (bus.imem_addr !== 32'(16 + 4*k)) begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, bus.imem_addr, 32'(16 + 4*k)); end
            total++; if (count !== 3'd4) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=4", k, count); end
            tick();
        end
    endtask

    task automatic test_mem_busy();
        mem_busy = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL busy_req[%0d] got=%b exp=0", k, bus.imem_req); end
            total++; if (bus.imem_addr !== 32'h20) begin bad++; $display("FAIL busy_addr[%0d] got=%h exp=20", k, bus.imem_addr); end
            total++; if (bus.out_pc !== 32'(16 + 4*k)) begin bad++; $display("FAIL busy_pc[%0d] got=%h exp=%h", k, bus.out_pc, 32'(16 + 4*k)); end
            tick();
            total++; if (count !== 3'(3 - k)) begin bad++; $display("FAIL busy_count[%0d] got=%0d exp=%0d", k, count, 3 - k); end
        end
        mem_busy = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL resume_req got=%b exp=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h20) begin bad++; $display("FAIL resume_addr got=%h exp=20", bus.imem_addr); end
        total++; if (bus.out_pc !== 32'h1c) begin bad++; $display("FAIL resume_pc got=%h exp=1c", bus.out_pc); end
        tick();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL resume_count got=%0d exp=1", count); end
        bus.out_ready = 1'b0;
        tick();
        tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL refill_count got=%0d exp=3", count); end
        total++; if (bus.imem_addr !== 32'h2c) begin bad++; $display("FAIL refill_addr got=%h exp=2c", bus.imem_addr); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_instr !== 32'h33) begin bad++; $display("FAIL redir_instr got=%h exp=33", bus.out_instr); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", bus.imem_req); end
        tick();
        redirect_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", count); end
        total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=40", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL redir_fetch got=%b exp=1", bus.imem_req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_empty got=%b exp=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL redir_head_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_pc !== 32'h40) begin bad++; $display("FAIL redir_head_pc got=%h exp=40", bus.out_pc); end
        total++; if (bus.out_instr !== 32'h140) begin bad++; $display("FAIL redir_head_instr got=%h exp=140", bus.out_instr); end
    endtask

    task automatic test_redirect_busy();
        redirect_valid = 1'b1; redirect_pc = 32'h80; mem_busy = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rb_valid0 got=%b exp=0", bus.out_valid); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rb_req0 got=%b exp=0", bus.imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rb_req1 got=%b exp=0", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h80) begin bad++; $display("FAIL rb_addr1 got=%h exp=80", bus.imem_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rb_stale1 got=%b pc=%h exp=0", bus.out_valid, bus.out_pc); end
        tick();
        mem_busy = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rb_req2 got=%b exp=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h80) begin bad++; $display("FAIL rb_addr2 got=%h exp=80", bus.imem_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rb_stale2 got=%b pc=%h exp=0", bus.out_valid, bus.out_pc); end
        tick();
        total++; if (bus.out_pc !== 32'h80) begin bad++; $display("FAIL rb_head_pc got=%h exp=80", bus.out_pc); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rb_head_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        // Build count=2, fetch_pc=0x24 from a redirect to 0x1c with no pops.
        bus.out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL ar_pre_count got=%0d exp=2", count); end
        total++; if (bus.imem_addr !== 32'h24) begin bad++; $display("FAIL ar_pre_addr got=%h exp=24", bus.imem_addr); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL ar_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.out_instr !== 32'h33) begin bad++; $display("FAIL ar_instr got=%h exp=33", bus.out_instr); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h exp=0", bus.imem_addr); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL ar_rel_req got=%b exp=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL ar_rel_addr got=%h exp=0", bus.imem_addr); end
        tick();
        total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL ar_rel_pc got=%h exp=0", bus.out_pc); end
        total++; if (bus.out_instr !== 32'h100) begin bad++; $display("FAIL ar_rel_instr got=%h exp=100", bus.out_instr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_mem_busy();
        test_redirect();
        test_redirect_busy();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
